// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - cache/memory bus bundle around the shared memory port arbiter
interface mem_port_arbiter_if #(
  parameter int CNT_W = 3
);
  logic             i_req;
  logic [31:0]      i_addr;
  logic             i_ack;
  logic [31:0]      i_rdata;
  logic             i_done;
  logic             d_req;
  logic             d_we;
  logic [31:0]      d_addr;
  logic [31:0]      d_wdata;
  logic             d_ack;
  logic [31:0]      d_rdata;
  logic             d_done;
  logic [CNT_W-1:0] beat;
  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_ack;
  logic [31:0]      mem_rdata;
  logic             busy;

  // Arbiter side: takes cache requests and memory responses, drives everything else
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_ack, i_rdata, i_done, d_ack, d_rdata, d_done, beat,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  // Environment side: the two caches plus the memory
  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_ack, i_rdata, i_done, d_ack, d_rdata, d_done, beat,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin ICache/DCache line burst arbiter for the main memory port
module mem_port_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int CNT_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  localparam int              LSB       = CNT_W + 2;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic               owner_q;       // 0 = ICache, 1 = DCache
  logic               last_owner_q;
  logic               we_lat_q;
  logic [31:LSB]      base_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               any_req;
  logic               pick_d;
  logic               unused_addr_bits;

  // Byte-within-line bits are dropped: bursts always start at the line base
  assign unused_addr_bits = ^{bus.i_addr[LSB-1:0], bus.d_addr[LSB-1:0]};

  // A tie goes to whoever did not win last time; DCache wins the first tie after reset
  assign any_req = bus.i_req | bus.d_req;
  assign pick_d  = bus.d_req & (~bus.i_req | ~last_owner_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Grant capture and beat counter; only IDLE looks at the requests
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      we_lat_q     <= 1'b0;
      base_q       <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q      <= pick_d;
            last_owner_q <= pick_d;
            base_q       <= pick_d ? bus.d_addr[31:LSB] : bus.i_addr[31:LSB];
            we_lat_q     <= pick_d & bus.d_we;
            cnt_q        <= '0;
          end
        end
        BURST: begin
          if (bus.mem_ack) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next state and all outputs; everything is zero outside the states that drive it
  always_comb begin
    state_d       = state_q;
    bus.i_ack     = 1'b0;
    bus.i_rdata   = '0;
    bus.i_done    = 1'b0;
    bus.d_ack     = 1'b0;
    bus.d_rdata   = '0;
    bus.d_done    = 1'b0;
    bus.beat      = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = BURST;
      end
      BURST: begin
        bus.busy      = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_lat_q;
        bus.mem_addr  = {base_q, cnt_q, 2'b00};
        bus.beat      = cnt_q;
        bus.mem_wdata = (owner_q && we_lat_q) ? bus.d_wdata : 32'd0;
        if (bus.mem_ack) begin
          if (owner_q) begin
            bus.d_ack   = 1'b1;
            bus.d_rdata = bus.mem_rdata;
          end else begin
            bus.i_ack   = 1'b1;
            bus.i_rdata = bus.mem_rdata;
          end
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.d_done = owner_q;
        bus.i_done = ~owner_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LW    = 8;
  localparam int CW    = 3;
  localparam logic [31:0] LINE_MASK = ~32'(LW * 4 - 1);

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.CNT_W(CW)) bus ();

  mem_port_arbiter #(.LINE_WORDS(LW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus values applied on the next step
  logic        s_rst, s_i_req, s_d_req, s_d_we, s_mem_ack;
  logic [31:0] s_i_addr, s_d_addr, s_d_wdata, s_mem_rdata;

  // Reference model: who owns the port, how many beats have completed, done phase
  int          m_owner;   // -1 none, 0 ICache, 1 DCache
  int          m_beats;
  bit          m_done;
  int          m_last;
  logic [31:0] m_base;
  bit          m_we;

  // Observations from the latest step
  logic        o_i_done, o_d_done, o_i_ack;
  int          n_i_ack, n_d_ack, n_i_done, n_busy, n_we;
  bit          seen_req;
  logic [31:0] first_addr, last_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clr_counts();
    n_i_ack = 0; n_d_ack = 0; n_i_done = 0; n_busy = 0; n_we = 0;
    seen_req = 0; first_addr = '0; last_addr = '0;
  endtask

  // One clock: drive at negedge, compare every output against the model, advance the model at posedge
  task automatic step();
    logic        in_burst, ack;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    rst           = s_rst;
    bus.i_req     = s_i_req;
    bus.i_addr    = s_i_addr;
    bus.d_req     = s_d_req;
    bus.d_we      = s_d_we;
    bus.d_addr    = s_d_addr;
    bus.d_wdata   = s_d_wdata;
    bus.mem_ack   = s_mem_ack;
    bus.mem_rdata = s_mem_rdata;
    #1;
    in_burst = (m_owner >= 0) && !m_done;
    ack      = in_burst && s_mem_ack;
    e_addr   = in_burst ? m_base + 32'(m_beats * 4) : 32'd0;
    e_wdata  = (in_burst && m_we && m_owner == 1) ? s_d_wdata : 32'd0;
    chk("busy",      32'(bus.busy),    32'(m_owner >= 0));
    chk("mem_req",   32'(bus.mem_req), 32'(in_burst));
    chk("mem_we",    32'(bus.mem_we),  32'(in_burst && m_we));
    chk("mem_addr",  bus.mem_addr,     e_addr);
    chk("mem_wdata", bus.mem_wdata,    e_wdata);
    chk("beat",      32'(bus.beat),    in_burst ? 32'(m_beats) : 32'd0);
    chk("i_ack",     32'(bus.i_ack),   32'(ack && m_owner == 0));
    chk("i_rdata",   bus.i_rdata,      (ack && m_owner == 0) ? s_mem_rdata : 32'd0);
    chk("i_done",    32'(bus.i_done),  32'(m_done && m_owner == 0));
    chk("d_ack",     32'(bus.d_ack),   32'(ack && m_owner == 1));
    chk("d_rdata",   bus.d_rdata,      (ack && m_owner == 1) ? s_mem_rdata : 32'd0);
    chk("d_done",    32'(bus.d_done),  32'(m_done && m_owner == 1));
    o_i_done = bus.i_done;
    o_d_done = bus.d_done;
    o_i_ack  = bus.i_ack;
    n_i_ack  += int'(bus.i_ack);
    n_d_ack  += int'(bus.d_ack);
    n_i_done += int'(bus.i_done);
    n_busy   += int'(bus.busy);
    n_we     += int'(bus.mem_we);
    if (bus.mem_req && !seen_req) begin
      seen_req   = 1;
      first_addr = bus.mem_addr;
    end
    if (bus.mem_req && bus.mem_ack) last_addr = bus.mem_addr;
    @(posedge clk);
    if (s_rst) begin
      m_owner = -1; m_done = 0; m_beats = 0; m_last = 0;
    end else if (m_done) begin
      m_done = 0; m_owner = -1;
    end else if (m_owner >= 0) begin
      if (s_mem_ack) begin
        m_beats++;
        if (m_beats == LW) begin
          m_beats = 0;
          m_done  = 1;
        end
      end
    end else if (s_i_req || s_d_req) begin
      m_owner = (s_i_req && s_d_req) ? 1 - m_last : (s_d_req ? 1 : 0);
      m_last  = m_owner;
      m_base  = ((m_owner == 1) ? s_d_addr : s_i_addr) & LINE_MASK;
      m_we    = (m_owner == 1) ? s_d_we : 1'b0;
      m_beats = 0;
    end
  endtask

  int      order[$];
  int      cyc, d_done_cyc, iack_cyc, stall;
  bit      i_pend, d_pend, hit;

  initial begin
    rst = 1'b1;
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    m_owner = -1; m_beats = 0; m_done = 0; m_last = 0; m_base = '0; m_we = 0;
    s_rst = 1; s_i_req = 0; s_d_req = 0; s_d_we = 0; s_mem_ack = 0;
    s_i_addr = 0; s_d_addr = 0; s_d_wdata = 0; s_mem_rdata = 0;
    clr_counts();
    step(); step();

    // Zero-wait DCache refill from a mid-line address
    s_rst = 0; s_d_req = 1; s_d_we = 0; s_d_addr = 32'h0000_1234; s_mem_ack = 1;
    clr_counts(); hit = 0;
    for (int k = 0; k < 30 && !hit; k++) begin
      s_mem_rdata = $urandom; s_d_wdata = $urandom;
      step();
      if (o_d_done) begin hit = 1; s_d_req = 0; end
    end
    chk("t1_done_seen", 32'(hit), 32'd1);
    chk("t1_d_acks", 32'(n_d_ack), 32'd8);
    chk("t1_busy_cycles", 32'(n_busy), 32'd9);
    chk("t1_first_addr", first_addr, 32'h0000_1220);
    chk("t1_last_addr", last_addr, 32'h0000_123C);

    // Simultaneous requests after reset: D, then I right after, then D again
    s_rst = 1; step(); s_rst = 0;
    s_i_req = 1; s_d_req = 1; s_i_addr = $urandom; s_d_addr = $urandom; s_mem_ack = 1;
    cyc = 0; d_done_cyc = -1; iack_cyc = -1; order.delete();
    for (int k = 0; k < 80 && order.size() < 3; k++) begin
      s_mem_rdata = $urandom;
      step(); cyc++;
      if (o_i_ack && iack_cyc < 0) iack_cyc = cyc;
      if (o_d_done) begin
        order.push_back(1); s_d_req = 0;
        if (d_done_cyc < 0) d_done_cyc = cyc;
      end
      if (o_i_done) begin
        order.push_back(0); s_i_req = 0;
        if (order.size() == 2) begin s_i_req = 1; s_d_req = 1; end
      end
    end
    s_i_req = 0; s_d_req = 0;
    chk("t2_bursts", 32'(order.size()), 32'd3);
    chk("t2_first", (order.size() > 0) ? 32'(order[0]) : 32'd9, 32'd1);
    chk("t2_second", (order.size() > 1) ? 32'(order[1]) : 32'd9, 32'd0);
    chk("t2_third", (order.size() > 2) ? 32'(order[2]) : 32'd9, 32'd1);
    chk("t2_i_first_ack_gap", 32'(iack_cyc - d_done_cyc), 32'd2);

    // DCache writeback with memory stalling three cycles on beat 5
    step();
    s_d_req = 1; s_d_we = 1; s_d_addr = $urandom; stall = 0; hit = 0;
    clr_counts();
    for (int k = 0; k < 60 && !hit; k++) begin
      s_mem_ack = !(m_owner == 1 && !m_done && m_beats == 5 && stall < 3);
      if (!s_mem_ack) stall++;
      s_d_wdata = $urandom; s_mem_rdata = $urandom;
      step();
      if (o_d_done) begin hit = 1; s_d_req = 0; end
    end
    s_d_we = 0; s_mem_ack = 1;
    chk("t3_done_seen", 32'(hit), 32'd1);
    chk("t3_d_acks", 32'(n_d_ack), 32'd8);
    chk("t3_i_acks", 32'(n_i_ack), 32'd0);
    chk("t3_i_done", 32'(n_i_done), 32'd0);
    chk("t3_we_cycles", 32'(n_we), 32'd11);

    // Reset in the middle of an ICache burst; the held request restarts from beat 0
    step();
    s_i_req = 1; s_i_addr = $urandom; s_mem_ack = 1;
    for (int k = 0; k < 20 && !(m_owner == 0 && !m_done && m_beats == 4); k++) step();
    chk("t5_reached_beat4", 32'(m_owner == 0 && m_beats == 4), 32'd1);
    s_rst = 1; step(); s_rst = 0;
    clr_counts(); hit = 0;
    for (int k = 0; k < 30 && !hit; k++) begin
      s_mem_rdata = $urandom;
      step();
      if (o_i_done) begin hit = 1; s_i_req = 0; end
    end
    chk("t5_done_seen", 32'(hit), 32'd1);
    chk("t5_i_acks", 32'(n_i_ack), 32'd8);
    chk("t5_first_addr", first_addr, s_i_addr & LINE_MASK);
    chk("t5_busy_cycles", 32'(n_busy), 32'd9);

    // Randomized traffic: random stalls, stray acks, dropped requests, occasional reset
    i_pend = 0; d_pend = 0;
    for (int k = 0; k < 2500; k++) begin
      if (!i_pend && $urandom_range(0, 3) == 0) begin
        i_pend = 1; s_i_addr = $urandom;
      end
      if (!d_pend && $urandom_range(0, 3) == 0) begin
        d_pend = 1; s_d_addr = $urandom; s_d_we = 1'($urandom_range(0, 1));
      end
      if (i_pend && $urandom_range(0, 59) == 0) i_pend = 0;
      if (d_pend && $urandom_range(0, 59) == 0) d_pend = 0;
      s_i_req     = i_pend;
      s_d_req     = d_pend;
      s_mem_ack   = ($urandom_range(0, 9) < 7);
      s_mem_rdata = $urandom;
      s_d_wdata   = $urandom;
      s_rst       = ($urandom_range(0, 299) == 0);
      step();
      if (o_i_done) i_pend = 0;
      if (o_d_done) d_pend = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
